uart_tx_fifo: RTL and testbench

Buffered UART transmitter that drives the board uart_tx pin on behalf of the memory-mapped store path in the data memory. CPU byte writes to the UART data address push into a small FIFO. A serializer drains the FIFO as 8N1 frames at CLKS_PER_BIT clocks per bit, so back-to-back stores do not stall on the line rate. It runs entirely on cpu_clk (10 MHz).

---
 rtl/uart_tx_fifo.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte pushes land in a FIFO that a serializer drains.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned FIFO_DEPTH   = 16,
    localparam int unsigned CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             uart_tx
);

    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W  = AW + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic              full_q, empty_q;
    logic [7:0]        head;
    logic              push, pop;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              baud_done;
`ifdef UART_PARITY_EN
    logic              parity_q, parity_d;
`endif

    // A full FIFO drops the push even if the serializer pops on the same edge.
    assign push      = wr_en && !full_q;
    assign pop       = (state_q == StIdle) && !empty_q;
    assign wr_ptr_d  = wr_ptr_q + PTR_W'(push);
    assign rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
    assign head      = mem_q[rd_ptr_q[AW-1:0]];
    assign baud_done = (baud_q == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= CNT_W'(wr_ptr_d - rd_ptr_d);
            full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
            empty_q  <= (wr_ptr_d == rd_ptr_d);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
`ifdef UART_PARITY_EN
        parity_d  = parity_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!empty_q) begin
                    shift_d   = head;
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = StStart;
`ifdef UART_PARITY_EN
                    parity_d  = ^head;
`endif
                end
            end
            StStart: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = StData;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d    = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`ifdef UART_PARITY_EN
            StParity: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = StStop;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
`endif
            StStop: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = StIdle;
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // The line flop follows the current state, so each level appears one edge after its state.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_q)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_q[0];
`ifdef UART_PARITY_EN
            StParity: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
`ifdef UART_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
`ifdef UART_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;
    assign busy    = (state_q != StIdle) || !empty_q;
    assign uart_tx = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a slow instance at 87 clks/bit and a fast one at 4 clks/bit.
// Frame expectations follow UART_PARITY_EN when it is defined for the build.
module tb_uart_tx_fifo;

    localparam int unsigned SLOW_CPB = 87;
    localparam int unsigned FAST_CPB = 4;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned CW       = $clog2(DEPTH + 1);
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en_a, wr_en_b;
    logic [7:0]    wr_data_a, wr_data_b;
    logic          full_a, empty_a, busy_a, tx_a;
    logic          full_b, empty_b, busy_b, tx_b;
    logic [CW-1:0] count_a, count_b;
    logic          use_fast;
    logic          tx_mon;

    int n_cmp = 0;
    int n_bad = 0;
    int max_cnt = 0;

    assign tx_mon = use_fast ? tx_b : tx_a;

    always #50 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(SLOW_CPB), .FIFO_DEPTH(DEPTH)) dut_slow (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_a),
        .wr_data (wr_data_a),
        .full    (full_a),
        .empty   (empty_a),
        .count   (count_a),
        .busy    (busy_a),
        .uart_tx (tx_a)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(FAST_CPB), .FIFO_DEPTH(DEPTH)) dut_fast (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_b),
        .wr_data (wr_data_b),
        .full    (full_b),
        .empty   (empty_b),
        .count   (count_b),
        .busy    (busy_b),
        .uart_tx (tx_b)
    );

    always @(negedge clk) begin
        if (int'(count_b) > max_cnt) max_cnt = int'(count_b);
    end

    initial begin
        #(100 * 20000);
        $display("FAIL watchdog: simulation still running after 20000 cycles, required finish");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  data;
        logic [9:0]  frame10;  // {stop, d7..d0, start}
        logic [10:0] frame11;  // {stop, parity, d7..d0, start}
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] frame_model(input logic [7:0] d);
`ifdef UART_PARITY_EN
        return {1'b1, ^d, d, 1'b0};
`else
        return {1'b0, 1'b1, d, 1'b0};
`endif
    endfunction

    function automatic logic [10:0] vec_frame(input vec_t v);
`ifdef UART_PARITY_EN
        return v.frame11;
`else
        return {1'b0, v.frame10};
`endif
    endfunction

    task automatic push(input bit fast, input logic [7:0] d);
        @(negedge clk);
        if (fast) begin
            wr_en_b   = 1'b1;
            wr_data_b = d;
        end else begin
            wr_en_a   = 1'b1;
            wr_data_a = d;
        end
        @(posedge clk);
        #1;
        wr_en_a = 1'b0;
        wr_en_b = 1'b0;
    endtask

    // Entered on the negedge of the first start-bit cycle; every bit must hold for cpb samples.
    task automatic check_frame(input logic [10:0] exp, input int cpb, input string name);
        int bad;
        for (int b = 0; b < NBITS; b++) begin
            bad = 0;
            for (int k = 0; k < cpb; k++) begin
                if (b != 0 || k != 0) @(negedge clk);
                if (tx_mon !== exp[b]) bad++;
            end
            check($sformatf("%s bit%0d cycles off", name, b), bad, 0);
        end
    endtask

    task automatic wait_start(input int limit, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tx_mon !== 1'b0 && n < limit);
        check({name, " start bit"}, {31'd0, tx_mon}, 0);
    endtask

    task automatic check_gap(input string name);
        @(negedge clk);
        check({name, " gap high"}, {31'd0, tx_mon}, 1);
        @(negedge clk);
        check({name, " next start"}, {31'd0, tx_mon}, 0);
    endtask

    initial begin
        int bad;
        logic [7:0] pp_bytes [5];

        vecs[0] = '{8'h55, 10'h2AA, 11'h4AA};
        vecs[1] = '{8'hC3, 10'h386, 11'h586};
        vecs[2] = '{8'h00, 10'h200, 11'h400};
        vecs[3] = '{8'hFF, 10'h3FE, 11'h5FE};
        vecs[4] = '{8'h01, 10'h202, 11'h602};
        vecs[5] = '{8'h80, 10'h300, 11'h700};
        vecs[6] = '{8'h07, 10'h20E, 11'h60E};
        vecs[7] = '{8'h03, 10'h206, 11'h406};

        rst_n     = 1'b0;
        wr_en_a   = 1'b0;
        wr_en_b   = 1'b0;
        wr_data_a = '0;
        wr_data_b = '0;
        use_fast  = 1'b0;

        // Reset values, then a long idle stretch
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst slow tx", {31'd0, tx_a}, 1);
        check("rst slow full", {31'd0, full_a}, 0);
        check("rst slow empty", {31'd0, empty_a}, 1);
        check("rst slow count", {27'd0, count_a}, 0);
        check("rst slow busy", {31'd0, busy_a}, 0);
        check("rst fast tx", {31'd0, tx_b}, 1);
        check("rst fast empty", {31'd0, empty_b}, 1);
        check("rst fast count", {27'd0, count_b}, 0);
        check("rst fast busy", {31'd0, busy_b}, 0);
        rst_n = 1'b1;
        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (tx_a !== 1'b1 || empty_a !== 1'b1 || count_a !== '0 || busy_a !== 1'b0) bad++;
        end
        check("idle hold 1000 cycles off", bad, 0);

        // Single 0x55 at 87 clks/bit: start bit appears two edges after the push
        use_fast = 1'b0;
        push(1'b0, vecs[0].data);
        @(negedge clk);
        check("slow lat edge1 tx", {31'd0, tx_mon}, 1);
        @(negedge clk);
        check("slow lat edge2 tx", {31'd0, tx_mon}, 1);
        @(negedge clk);
        check("slow start at edge+2", {31'd0, tx_mon}, 0);
        check("slow busy in frame", {31'd0, busy_a}, 1);
        check_frame(vec_frame(vecs[0]), SLOW_CPB, "slow 55");
        @(negedge clk);
        check("slow after frame tx", {31'd0, tx_mon}, 1);
        check("slow after frame busy", {31'd0, busy_a}, 0);

        // Table of single frames at 4 clks/bit
        use_fast = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push(1'b1, vecs[i].data);
            @(negedge clk);
            @(negedge clk);
            check($sformatf("vec%0d pre-start tx", i), {31'd0, tx_mon}, 1);
            @(negedge clk);
            check($sformatf("vec%0d start edge", i), {31'd0, tx_mon}, 0);
            check_frame(vec_frame(vecs[i]), FAST_CPB, $sformatf("vec%0d", i));
            @(negedge clk);
            check($sformatf("vec%0d idle tx", i), {31'd0, tx_mon}, 1);
            check($sformatf("vec%0d idle busy", i), {31'd0, busy_b}, 0);
            check($sformatf("vec%0d idle empty", i), {31'd0, empty_b}, 1);
        end

        // Fill: the first byte is already serializing, so 17 pushes leave 16 queued
        max_cnt = 0;
        fork
            begin
                for (int i = 0; i < 17; i++) push(1'b1, 8'(i));
                check("fill count", {27'd0, count_b}, 16);
                check("fill full", {31'd0, full_b}, 1);
                push(1'b1, 8'hAA);
                check("drop count", {27'd0, count_b}, 16);
                check("drop full", {31'd0, full_b}, 1);
            end
            begin
                wait_start(20, "fill");
                for (int i = 0; i < 17; i++) begin
                    check_frame(frame_model(8'(i)), FAST_CPB, $sformatf("fill frame%0d", i));
                    if (i < 16) check_gap($sformatf("fill frame%0d", i));
                end
            end
        join
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_mon !== 1'b1) bad++;
        end
        check("dropped AA never sent, cycles off", bad, 0);
        check("max count", max_cnt, 16);
        check("fill drained empty", {31'd0, empty_b}, 1);

        // Push on the exact edge IDLE pops the head with three queued
        pp_bytes = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h41};
        fork
            begin
                for (int i = 0; i < 4; i++) push(1'b1, pp_bytes[i]);
                repeat (NBITS * FAST_CPB - 2) @(posedge clk);
                #1;
                check("pp count before", {27'd0, count_b}, 3);
                push(1'b1, 8'h41);
                check("pp count after", {27'd0, count_b}, 3);
            end
            begin
                wait_start(20, "pp");
                for (int i = 0; i < 5; i++) begin
                    check_frame(frame_model(pp_bytes[i]), FAST_CPB, $sformatf("pp frame%0d", i));
                    if (i < 4) check_gap($sformatf("pp frame%0d", i));
                end
            end
        join
        @(negedge clk);
        check("pp idle busy", {31'd0, busy_b}, 0);

        // Reset during data bit 3 of 0xC3 with four bytes behind it
        push(1'b1, 8'hC3);
        for (int i = 1; i < 5; i++) push(1'b1, 8'(i));
        repeat (14) @(posedge clk);
        #1;
        check("mid bit3 tx", {31'd0, tx_b}, 0);
        check("mid count", {27'd0, count_b}, 4);
        check("mid busy", {31'd0, busy_b}, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort tx", {31'd0, tx_b}, 1);
        check("abort count", {27'd0, count_b}, 0);
        check("abort empty", {31'd0, empty_b}, 1);
        check("abort busy", {31'd0, busy_b}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_b !== 1'b1 || busy_b !== 1'b0) bad++;
        end
        check("post-abort quiet cycles off", bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
